// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store memory stage: funct3 size codes,
// FSM state encoding, byte-strobe constants and funct3 decode helpers.
package lsu_mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] WSTRB_B = 4'b0001;
    localparam logic [3:0] WSTRB_H = 4'b0011;
    localparam logic [3:0] WSTRB_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_WB       = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Unused funct3 encodings fall through to a full-word access.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            default:     f3_size = SZ_W;
        endcase
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        f3_unsigned = (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication and strobe generation, and
// load byte/half selection with sign or zero extension.
module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_wstrb,
    output logic [31:0] load_data
);

    lsu_size_e   size;
    logic        is_unsigned;
    logic [7:0]  rbytes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign size        = f3_size(funct3);
    assign is_unsigned = f3_unsigned(funct3);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbytes[gi] = rdata[gi*8 +: 8];
            assign lane_wdata[gi*8 +: 8] =
                (size == SZ_B) ? store_data[7:0] :
                (size == SZ_H) ? store_data[(gi % 2)*8 +: 8] :
                                 store_data[gi*8 +: 8];
        end
    endgenerate

    // Halfwords are located by addr[1] only; addr[0] never moves a half.
    assign byte_sel = rbytes[off];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        lane_wstrb = WSTRB_W;
        load_data  = rdata;
        case (size)
            SZ_B: begin
                lane_wstrb = WSTRB_B << off;
                load_data  = is_unsigned ? {24'd0, byte_sel}
                                         : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                lane_wstrb = WSTRB_H << {off[1], 1'b0};
                load_data  = is_unsigned ? {16'd0, half_sel}
                                         : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                lane_wstrb = WSTRB_W;
                load_data  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one outstanding data-RAM access with timeout.
// Optional LSU_MISALIGN_CHK_EN rejects misaligned H/W accesses via misalign_o.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rd_wr_en_o,
    output logic [4:0]        rd_o,
    output logic [DATA_W-1:0] rd_reg_data_o,
    output logic              hold_flag_o,
`ifdef LSU_MISALIGN_CHK_EN
    output logic              misalign_o,
`endif
    output logic              bus_err_o
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(RSP_TIMEOUT);

    lsu_state_e        state_reg, state_next;
    logic              we_reg;
    logic [2:0]        f3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [4:0]        rd_reg;
    logic [7:0]        cnt_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              accept;
    logic              timed_out;
    logic              busy_extra;
    logic              reject_req;
    logic [DATA_W-1:0] lane_wdata;
    logic [3:0]        lane_wstrb;
    logic [DATA_W-1:0] load_data;

`ifdef LSU_MISALIGN_CHK_EN
    logic      misalign_reg;
    lsu_size_e req_size;

    assign req_size   = f3_size(req_funct3_i);
    assign reject_req = ((req_size == SZ_H) && req_addr_i[0]) ||
                        ((req_size == SZ_W) && (req_addr_i[1:0] != 2'b00));
    assign busy_extra = misalign_reg;
    assign misalign_o = misalign_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= accept && reject_req;
        end
    end
`else
    assign reject_req = 1'b0;
    assign busy_extra = 1'b0;
`endif

    assign accept    = (state_reg == ST_IDLE) && !busy_extra && req_valid_i;
    assign timed_out = (state_reg == ST_WAIT_RSP) && !mem_rsp_valid_i &&
                       (cnt_reg == TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && !reject_req) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready_i) begin
                    state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_valid_i) begin
                    state_next = we_reg ? ST_IDLE : ST_WB;
                end else if (timed_out) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Captured request fields, response timer and returned read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg    <= 1'b0;
            f3_reg    <= 3'd0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rd_reg    <= 5'd0;
            cnt_reg   <= 8'd0;
            rdata_reg <= '0;
        end else begin
            if (accept) begin
                we_reg    <= req_we_i;
                f3_reg    <= req_funct3_i;
                addr_reg  <= req_addr_i;
                wdata_reg <= req_wdata_i;
                rd_reg    <= req_rd_i;
            end
            cnt_reg <= (state_reg == ST_WAIT_RSP) ? cnt_reg + 8'd1 : 8'd0;
            if ((state_reg == ST_WAIT_RSP) && mem_rsp_valid_i) begin
                rdata_reg <= mem_rdata_i;
            end
        end
    end

    lsu_align u_align (
        .funct3     (f3_reg),
        .off        (addr_reg[1:0]),
        .store_data (wdata_reg),
        .rdata      (rdata_reg),
        .lane_wdata (lane_wdata),
        .lane_wstrb (lane_wstrb),
        .load_data  (load_data)
    );

    always_comb begin
        req_ready_o     = (state_reg == ST_IDLE) && !busy_extra;
        hold_flag_o     = (state_reg != ST_IDLE) || busy_extra;
        mem_req_valid_o = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        mem_wstrb_o     = 4'd0;
        rd_wr_en_o      = 1'b0;
        rd_o            = 5'd0;
        rd_reg_data_o   = '0;
        bus_err_o       = timed_out;
        if (state_reg == ST_REQ) begin
            mem_req_valid_o = 1'b1;
            mem_we_o        = we_reg;
            mem_addr_o      = {addr_reg[ADDR_W-1:2], 2'b00};
            mem_wdata_o     = we_reg ? lane_wdata : '0;
            mem_wstrb_o     = we_reg ? lane_wstrb : 4'd0;
        end
        if (state_reg == ST_WB) begin
            rd_wr_en_o    = (rd_reg != 5'd0);
            rd_o          = rd_reg;
            rd_reg_data_o = load_data;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a transaction-level model predicts every
// cycle's outputs, and a negedge compare process checks the DUT against it.
module tb_lsu_mem_stage;

    localparam int RSP_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rdata_i;
    logic        rd_wr_en_o;
    logic [4:0]  rd_o;
    logic [31:0] rd_reg_data_o;
    logic        hold_flag_o, bus_err_o;
`ifdef LSU_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    lsu_mem_stage #(.ADDR_W(32), .DATA_W(32), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_we_i        (req_we_i),
        .req_funct3_i    (req_funct3_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .req_rd_i        (req_rd_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wstrb_o     (mem_wstrb_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rdata_i     (mem_rdata_i),
        .rd_wr_en_o      (rd_wr_en_o),
        .rd_o            (rd_o),
        .rd_reg_data_o   (rd_reg_data_o),
        .hold_flag_o     (hold_flag_o),
`ifdef LSU_MISALIGN_CHK_EN
        .misalign_o      (misalign_o),
`endif
        .bus_err_o       (bus_err_o)
    );

    typedef struct packed {
        logic        req_ready, hold, mem_valid, mem_we, rd_wr_en, bus_err, misalign;
        logic        chk_bus, chk_store, chk_rd;
        logic [31:0] addr, wdata, data;
        logic [3:0]  wstrb;
        logic [4:0]  rd;
    } exp_t;

    exp_t e;
    bit   chk_on = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   txn_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: access size in bytes; unused funct3 codes behave as words.
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        int off = int'(addr[1:0]);
        case (nbytes(f3))
            1:       return 4'(1 << off);
            2:       return 4'(3 << (off & 2));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (nbytes(f3))
            1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int          off = int'(addr[1:0]);
        logic [31:0] v;
        case (nbytes(f3))
            1: begin
                v = (rdata >> (8 * off)) & 32'hFF;
                if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
            end
            2: begin
                v = (rdata >> (8 * (off & 2))) & 32'hFFFF;
                if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic exp_t idle_exp();
        exp_t x = '0;
        x.req_ready = 1'b1;
        return x;
    endfunction

    function automatic exp_t reset_exp();
        exp_t x = '0;
        x.req_ready = 1'b1;
        x.chk_bus   = 1'b1;
        x.chk_store = 1'b1;
        x.chk_rd    = 1'b1;
        return x;
    endfunction

    function automatic exp_t busy_exp();
        exp_t x = '0;
        x.hold = 1'b1;
        return x;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_ready_o", 32'(req_ready_o), 32'(e.req_ready));
            chk("hold_flag_o", 32'(hold_flag_o), 32'(e.hold));
            chk("mem_req_valid_o", 32'(mem_req_valid_o), 32'(e.mem_valid));
            chk("rd_wr_en_o", 32'(rd_wr_en_o), 32'(e.rd_wr_en));
            chk("bus_err_o", 32'(bus_err_o), 32'(e.bus_err));
`ifdef LSU_MISALIGN_CHK_EN
            chk("misalign_o", 32'(misalign_o), 32'(e.misalign));
`endif
            if (e.chk_bus) begin
                chk("mem_addr_o", mem_addr_o, e.addr);
                chk("mem_we_o", 32'(mem_we_o), 32'(e.mem_we));
            end
            if (e.chk_store) begin
                chk("mem_wdata_o", mem_wdata_o, e.wdata);
                chk("mem_wstrb_o", 32'(mem_wstrb_o), 32'(e.wstrb));
            end
            if (e.chk_rd) begin
                chk("rd_o", 32'(rd_o), 32'(e.rd));
                chk("rd_reg_data_o", rd_reg_data_o, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rsp_dly < 0 means the memory never answers.
    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
        bit got = 1'b0;
        bit err = 1'b0;
        exp_t x;
        txn_no++;
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wd; req_rd_i = rd;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = 32'hA5A5_A5A5;
        e = idle_exp();
        step();
        req_valid_i = 1'b0;
        req_addr_i = 32'hFFFF_FFFF; req_wdata_i = 32'h0; req_rd_i = 5'd31;
        x = busy_exp();
        x.mem_valid = 1'b1; x.chk_bus = 1'b1; x.mem_we = we;
        x.addr = addr & 32'hFFFF_FFFC;
        x.chk_store = we; x.wdata = m_wdata(f3, wd); x.wstrb = m_wstrb(f3, addr);
        e = x;
        for (int k = 0; k <= rdy_dly; k++) begin
            mem_req_ready_i = (k == rdy_dly);
            step();
        end
        mem_req_ready_i = 1'b0;
        for (int j = 0; j <= RSP_TIMEOUT; j++) begin
            x = busy_exp();
            mem_rsp_valid_i = (j == rsp_dly);
            mem_rdata_i = (j == rsp_dly) ? rdata : 32'hA5A5_A5A5;
            if (rsp_dly < 0 && j == RSP_TIMEOUT) begin
                x.bus_err = 1'b1;
                err = 1'b1;
            end
            e = x;
            step();
            mem_rsp_valid_i = 1'b0;
            mem_rdata_i = 32'hA5A5_A5A5;
            if (j == rsp_dly) begin
                got = 1'b1;
                break;
            end
            if (err) break;
        end
        if (!we && got) begin
            x = busy_exp();
            x.rd_wr_en = (rd != 5'd0);
            x.chk_rd = (rd != 5'd0);
            x.rd = rd;
            x.data = m_load(f3, addr, rdata);
            e = x;
            step();
        end
        e = idle_exp();
        step();
        $display("txn %0d: we=%0d f3=%03b addr=%h wdata=%h rd=%0d rdy_dly=%0d rsp_dly=%0d rdata=%h",
                 txn_no, we, f3, addr, wd, rd, rdy_dly, rsp_dly, rdata);
    endtask

    task automatic pin(input string name, input logic [31:0] model, input logic [31:0] literal);
        chk(name, model, literal);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'd0;
        req_addr_i = 32'd0; req_wdata_i = 32'd0; req_rd_i = 5'd0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        e = reset_exp();
        chk_on = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Hand-computed values that pin the model.
        pin("model_sw_wstrb", 32'(m_wstrb(3'b010, 32'h100)), 32'hF);
        pin("model_sb_wstrb", 32'(m_wstrb(3'b000, 32'h103)), 32'h8);
        pin("model_sb_wdata", m_wdata(3'b000, 32'h1234_56AB), 32'hABAB_ABAB);
        pin("model_sh_wstrb", 32'(m_wstrb(3'b001, 32'h102)), 32'hC);
        pin("model_lb", m_load(3'b000, 32'h103, 32'hAB00_0000), 32'hFFFF_FFAB);
        pin("model_lbu", m_load(3'b100, 32'h103, 32'hAB00_0000), 32'h0000_00AB);
        pin("model_lh", m_load(3'b001, 32'h102, 32'h8001_1234), 32'hFFFF_8001);
        pin("model_lhu", m_load(3'b101, 32'h102, 32'h8001_1234), 32'h0000_8001);
        pin("model_lb_pos", m_load(3'b000, 32'h101, 32'h0000_7F00), 32'h0000_007F);

        run_txn(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'h0);
        run_txn(1'b1, 3'b000, 32'h103, 32'h1234_56AB, 5'd0, 0, 0, 32'h0);
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 5'd3, 0, 0, 32'hAB00_0000);
        run_txn(1'b0, 3'b100, 32'h103, 32'h0, 5'd4, 0, 0, 32'hAB00_0000);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 5'd5, 0, 0, 32'h8001_1234);
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 5'd6, 0, 0, 32'h8001_1234);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 5'd0, 0, 0, 32'h8001_1234);
        run_txn(1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 5'd0, 4, 1, 32'h0);
        run_txn(1'b0, 3'b010, 32'h104, 32'h0, 5'd9, 2, 3, 32'h1234_5678);
        run_txn(1'b0, 3'b011, 32'h108, 32'h0, 5'd10, 0, 0, 32'h8765_4321);
        run_txn(1'b1, 3'b111, 32'h10C, 32'hCAFE_F00D, 5'd0, 0, 0, 32'h0);
        run_txn(1'b0, 3'b000, 32'h101, 32'h0, 5'd11, 1, 0, 32'h0000_7F00);
`ifndef LSU_MISALIGN_CHK_EN
        run_txn(1'b0, 3'b010, 32'h102, 32'h0, 5'd12, 0, 0, 32'h1357_9BDF);
`endif

        // Response while idle must be ignored.
        e = idle_exp();
        mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        step();
        mem_rsp_valid_i = 1'b0;
        step();
        $display("txn spurious_rsp: rsp in IDLE");

        // No response: bus error after the timeout, no writeback.
        run_txn(1'b0, 3'b010, 32'h200, 32'h0, 5'd7, 0, -1, 32'h0);

        // Reset in WAIT_RSP followed by a late response.
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
        req_addr_i = 32'h300; req_rd_i = 5'd8;
        e = idle_exp();
        step();
        req_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        e = busy_exp(); e.mem_valid = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        e = busy_exp();
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h7777_8888;
        e = reset_exp();
        step();
        mem_rsp_valid_i = 1'b0;
        step();
        step();
        $display("txn reset_mid: rst in WAIT_RSP, late rsp dropped");

`ifdef LSU_MISALIGN_CHK_EN
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
        req_addr_i = 32'h102; req_rd_i = 5'd9;
        e = idle_exp();
        step();
        req_valid_i = 1'b0;
        e = '0; e.hold = 1'b1; e.misalign = 1'b1;
        step();
        e = idle_exp();
        step();
        step();
        $display("txn misalign: LW at 0x102 rejected");
`endif

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
